// File: rtl/monopix_ro_pkg.sv
// Shared types for the MONOPIX flavour readout: controller states and the hit word layout.
package monopix_ro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TOKEN_WAIT,
      READ,
      LAT,
      SHIFT,
      STORE
   } t_state;

   typedef struct packed {
      logic [5:0] col;
      logic [5:0] te;
      logic [5:0] le;
      logic [8:0] row;
   } t_hit;

   localparam int HIT_W = $bits(t_hit);

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/monopix_ro_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is registered and holds its value when empty.
// A push while full is taken only if a pop happens in the same cycle.
module monopix_ro_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 16
) (
   input  logic                   clk_bx,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wdata,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW-1:0]    rd_nxt;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [WIDTH-1:0] head_q;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_ptr_q + 1'b1;
   assign rdata   = head_q;
   assign count   = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (!do_push && do_pop)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk_bx) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop)
            rd_ptr_q <= rd_nxt;
         cnt_q <= cnt_d;
         // Head tracks the next entry, or the incoming word when it lands in an empty/emptying FIFO.
         if (do_pop && (cnt_q > CW'(1)))
            head_q <= mem_q[rd_nxt];
         else if (do_push && ((cnt_q == '0) || (do_pop && (cnt_q == CW'(1)))))
            head_q <= wdata;
      end
   end

endmodule

// File: rtl/monopix_readout_ctrl.sv
// Readout controller for one MONOPIX flavour: TOKEN-driven FREEZE/READ sequencing, serial
// hit-word capture into an FWFT FIFO with valid/ready output, and saturating hit/overflow counters.
module monopix_readout_ctrl
   import monopix_ro_pkg::*;
#(
   parameter int DATA_W     = HIT_W,
   parameter int FIFO_DEPTH = 16,
   parameter int DLY_W      = 8
) (
   input  logic              clk_bx,
   input  logic              reset,
   input  logic              enable,
   input  logic [DLY_W-1:0]  cfg_wait,
   input  logic [DLY_W-1:0]  cfg_read,
   input  logic [DLY_W-1:0]  cfg_lat,
   input  logic              token,
   input  logic              data_in,
   output logic              freeze,
   output logic              read,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [31:0]       hit_cnt,
   output logic [15:0]       overflow_cnt
);
   localparam int PH_W  = max_int(DLY_W, $clog2(DATA_W));
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   t_state            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [DLY_W-1:0]  wait_cfg_q, read_cfg_q, lat_cfg_q;
   logic [DATA_W-1:0] ser_q, ser_d;
   logic              freeze_q, read_q, busy_q;
   logic [31:0]       hit_q, hit_d;
   logic [15:0]       ovf_q, ovf_d;
   logic              latch_cfg;
   logic              store;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q + 1'b1;
      ser_d     = ser_q;
      latch_cfg = 1'b0;
      store     = 1'b0;
      case (state_q)
         IDLE: begin
            if (enable && token) begin
               state_d   = TOKEN_WAIT;
               latch_cfg = 1'b1;
            end
         end
         TOKEN_WAIT: if (phase_q == PH_W'(wait_cfg_q)) state_d = READ;
         READ:       if (phase_q == PH_W'(read_cfg_q)) state_d = LAT;
         LAT:        if (phase_q == PH_W'(lat_cfg_q))  state_d = SHIFT;
         SHIFT: begin
            ser_d = {ser_q[DATA_W-2:0], data_in};
            if (phase_q == PH_W'(DATA_W - 1)) state_d = STORE;
         end
         STORE: begin
            store = 1'b1;
            if (enable && token) begin
               state_d   = TOKEN_WAIT;
               latch_cfg = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Every phase starts counting from zero, including TOKEN_WAIT re-entered from STORE.
      if (state_d != state_q)
         phase_d = '0;
   end

   assign pop  = out_valid && out_ready;
   assign drop = store && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop;

   always_comb begin
      hit_d = hit_q;
      ovf_d = ovf_q;
      if (store && (hit_q != '1))
         hit_d = hit_q + 32'd1;
      if (drop && (ovf_q != '1))
         ovf_d = ovf_q + 16'd1;
   end

   always_ff @(posedge clk_bx) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         ser_q      <= '0;
         wait_cfg_q <= '0;
         read_cfg_q <= '0;
         lat_cfg_q  <= '0;
         freeze_q   <= 1'b0;
         read_q     <= 1'b0;
         busy_q     <= 1'b0;
         hit_q      <= '0;
         ovf_q      <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         ser_q   <= ser_d;
         if (latch_cfg) begin
            wait_cfg_q <= cfg_wait;
            read_cfg_q <= cfg_read;
            lat_cfg_q  <= cfg_lat;
         end
         freeze_q <= (state_q == TOKEN_WAIT) || (state_q == READ);
         read_q   <= (state_q == READ);
         busy_q   <= (state_q != IDLE);
         hit_q    <= hit_d;
         ovf_q    <= ovf_d;
      end
   end

   monopix_ro_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_bx (clk_bx),
      .reset  (reset),
      .push   (store && (!fifo_full || pop)),
      .wdata  (ser_q),
      .pop    (pop),
      .rdata  (out_data),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   assign out_valid    = !fifo_empty;
   assign freeze       = freeze_q;
   assign read         = read_q;
   assign busy         = busy_q;
   assign hit_cnt      = hit_q;
   assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_monopix_readout_ctrl.sv
// Directed + randomized bench for monopix_readout_ctrl; a queue-level model predicts FIFO contents,
// counters and the FREEZE/READ/busy pad timing from the per-word cycle budget.
module tb_monopix_readout_ctrl;
   localparam int DW    = 27;
   localparam int DEPTH = 4;

   logic        clk_bx    = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic        token     = 1'b0;
   logic        data_in   = 1'b0;
   logic        out_ready = 1'b0;
   logic [7:0]  cfg_wait  = '0;
   logic [7:0]  cfg_read  = '0;
   logic [7:0]  cfg_lat   = '0;
   logic        freeze, read, out_valid, busy;
   logic [DW-1:0] out_data;
   logic [31:0] hit_cnt;
   logic [15:0] overflow_cnt;

   always #5 clk_bx = ~clk_bx;

   monopix_readout_ctrl #(
      .DATA_W     (DW),
      .FIFO_DEPTH (DEPTH),
      .DLY_W      (8)
   ) dut (
      .clk_bx       (clk_bx),
      .reset        (reset),
      .enable       (enable),
      .cfg_wait     (cfg_wait),
      .cfg_read     (cfg_read),
      .cfg_lat      (cfg_lat),
      .token        (token),
      .data_in      (data_in),
      .freeze       (freeze),
      .read         (read),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .hit_cnt      (hit_cnt),
      .overflow_cnt (overflow_cnt)
   );

   int            vectors     = 0;
   int            miscompares = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_head   = '0;
   logic [DW-1:0] cur_word    = '0;
   logic [31:0]   exp_hit     = '0;
   logic [15:0]   exp_ovf     = '0;
   bit            store_next  = 1'b0;
   bit            rand_ready  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: check FIFO/counters mid-cycle, then advance the model across the rising edge.
   task automatic tick();
      bit popped;
      @(negedge clk_bx);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) last_head = exp_q[0];
      chk("out_data", {5'd0, out_data}, {5'd0, last_head});
      chk("hit_cnt", hit_cnt, exp_hit);
      chk("overflow_cnt", {16'd0, overflow_cnt}, {16'd0, exp_ovf});
      popped = out_ready && (exp_q.size() > 0);
      @(posedge clk_bx);
      if (reset) begin
         exp_q.delete();
         exp_hit    = '0;
         exp_ovf    = '0;
         last_head  = '0;
         store_next = 1'b0;
      end else begin
         if (popped) void'(exp_q.pop_front());
         if (store_next) begin
            if (exp_hit != '1) exp_hit++;
            if (exp_q.size() < DEPTH) exp_q.push_back(cur_word);
            else if (exp_ovf != '1) exp_ovf++;
            store_next = 1'b0;
         end
      end
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   // Entered just after an edge; the next edge samples token (IDLE) or ends the previous STORE.
   // Returns during the STORE cycle of this word.
   task automatic send_word(input logic [DW-1:0] wd, input int w, input int r, input int l,
                            input bit chain, input bit perturb, input int drop_at);
      int s;
      s        = w + r + l + 3;
      cfg_wait = 8'(w);
      cfg_read = 8'(r);
      cfg_lat  = 8'(l);
      token    = 1'b1;
      for (int k = 0; k <= s; k++) begin
         tick();
         if (k == 0 && perturb) begin
            cfg_wait = 8'($urandom_range(0, 9));
            cfg_read = 8'($urandom_range(0, 9));
            cfg_lat  = 8'($urandom_range(0, 9));
         end
         chk("freeze", {31'd0, freeze}, {31'd0, (k >= 1) && (k <= w + r + 2)});
         chk("read", {31'd0, read}, {31'd0, (k >= w + 2) && (k <= w + r + 2)});
         chk("busy", {31'd0, busy}, {31'd0, (k >= 1) || chain});
      end
      for (int b = DW - 1; b >= 0; b--) begin
         data_in = wd[b];
         if ((DW - 1 - b) == drop_at) begin
            enable   = 1'b0;
            cfg_wait = 8'd9;
         end
         tick();
         chk("freeze_shift", {31'd0, freeze}, 32'd0);
         chk("busy_shift", {31'd0, busy}, 32'd1);
      end
      cur_word   = wd;
      store_next = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] wd;
      int            w, r, l;

      // Reset state
      @(posedge clk_bx);
      @(posedge clk_bx);
      #1;
      chk("rst_freeze", {31'd0, freeze}, 32'd0);
      chk("rst_read", {31'd0, read}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_data", {5'd0, out_data}, 32'd0);
      chk("rst_hit", hit_cnt, 32'd0);
      chk("rst_ovf", {16'd0, overflow_cnt}, 32'd0);
      reset  = 1'b0;
      enable = 1'b1;
      tick();

      // Basic word, cfg 2/1/3: out_valid 37 cycles after token is sampled
      send_word(27'h5A5A5A5, 2, 1, 3, 1'b0, 1'b0, -1);
      token = 1'b0;
      tick();
      chk("basic_valid", {31'd0, out_valid}, 32'd1);
      chk("basic_data", {5'd0, out_data}, 32'h5A5A5A5);
      chk("basic_hit", hit_cnt, 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();

      // Back-to-back: three words with token held high
      for (int i = 0; i < 3; i++)
         send_word(DW'($urandom), 2, 1, 3, i != 0, 1'b0, -1);
      token = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;

      // Overflow: six words into a four-entry FIFO with no consumer, random timing
      for (int i = 0; i < 6; i++)
         send_word(DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), i != 0, 1'b1, -1);
      token = 1'b0;
      tick();
      chk("ovf_total", {16'd0, overflow_cnt}, {16'd0, exp_ovf});
      out_ready = 1'b1;
      repeat (5) tick();
      out_ready = 1'b0;

      // Full FIFO with a pop in the STORE cycle
      for (int i = 0; i < 5; i++)
         send_word(DW'($urandom), 0, 0, 0, i != 0, 1'b0, -1);
      token     = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (5) tick();
      out_ready = 1'b0;

      // Enable dropped and cfg_wait changed mid-SHIFT: word completes, then IDLE despite token
      send_word(DW'($urandom), 2, 1, 3, 1'b0, 1'b0, 10);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("dis_busy", {31'd0, busy}, 32'd0);
         chk("dis_freeze", {31'd0, freeze}, 32'd0);
      end
      enable = 1'b1;
      token  = 1'b0;
      tick();

      // Randomized words and timing with a random consumer
      rand_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wd = DW'($urandom);
         w  = $urandom_range(0, 4);
         r  = $urandom_range(0, 4);
         l  = $urandom_range(0, 4);
         send_word(wd, w, r, l, i != 0, 1'b1, -1);
      end
      token = 1'b0;
      tick();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      repeat (7) tick();
      out_ready = 1'b0;

      // Reset while READ is high, with words waiting in the FIFO
      send_word(DW'($urandom), 0, 0, 0, 1'b0, 1'b0, -1);
      send_word(DW'($urandom), 0, 0, 0, 1'b1, 1'b0, -1);
      cfg_wait = 8'd1;
      cfg_read = 8'd2;
      cfg_lat  = 8'd0;
      for (int k = 0; k <= 3; k++) tick();
      chk("pre_rst_read", {31'd0, read}, 32'd1);
      reset = 1'b1;
      tick();
      chk("mid_rst_read", {31'd0, read}, 32'd0);
      chk("mid_rst_freeze", {31'd0, freeze}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_hit", hit_cnt, 32'd0);
      chk("mid_rst_ovf", {16'd0, overflow_cnt}, 32'd0);
      reset = 1'b0;
      token = 1'b0;
      tick();
      send_word(DW'($urandom), 1, 0, 2, 1'b0, 1'b0, -1);
      token = 1'b0;
      tick();
      out_ready = 1'b1;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/monopix_readout_ctrl.md
Name: monopix_readout_ctrl

Overview:
- Parametrised, synthesizable single-clock readout controller for one MONOPIX flavour output (PMOS_NOSF, PMOS, COMP or HV).
- Drives the chip's FREEZE/READ pads from the flavour's TOKEN pad and deserialises the hit word arriving on OUT.
- Buffers decoded words in an output FIFO with a valid/ready handshake toward the DAQ.
- Adds runtime-programmable timing, an enable, and saturating hit/overflow counters.
- One instance per flavour, in the FPGA-side readout.

Parameters:
- DATA_W, 27, serial hit word width (col 6, te 6, le 6, row 9).
- FIFO_DEPTH, 16, output FIFO entries; power of two, at least 2.
- DLY_W, 8, width of the timing configuration fields.

Ports:
- clk_bx  in  1  bunch-crossing clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  allows new token service.
- cfg_wait  in  DLY_W  extra TOKEN_WAIT cycles.
- cfg_read  in  DLY_W  extra READ cycles.
- cfg_lat  in  DLY_W  extra cycles from READ end to the first data bit.
- token  in  1  chip TOKEN pad.
- data_in  in  1  chip OUT pad, MSB first.
- freeze  out  1  chip FREEZE pad.
- read  out  1  chip READ pad.
- out_data  out  DATA_W  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.
- busy  out  1  state is not IDLE.
- hit_cnt  out  32  words captured, saturating.
- overflow_cnt  out  16  words dropped because the FIFO was full, saturating.

Behaviour:
- Reset: state IDLE; freeze, read, out_valid, busy = 0; out_data = 0; both counters = 0; FIFO empty; shadow config = 0. Reset mid-word discards the partial word and raises no strobe.
- Config shadowing: cfg_wait, cfg_read, cfg_lat are latched into shadow registers on every transition into TOKEN_WAIT. Changes during a word have no effect on that word.
- A phase counter is cleared on every state change.
- IDLE: if enable and token, go to TOKEN_WAIT.
- TOKEN_WAIT: lasts cfg_wait+1 cycles, then READ.
- READ: lasts cfg_read+1 cycles, then LAT.
- LAT: lasts cfg_lat+1 cycles, then SHIFT.
- SHIFT: exactly DATA_W cycles. Each cycle, ser <= {ser[DATA_W-2:0], data_in}, so the first bit sampled ends in bit DATA_W-1. Then STORE.
- STORE: exactly 1 cycle.
  - Pushes ser into the FIFO and increments hit_cnt.
  - If the FIFO is full and no pop happens this cycle, the word is dropped and overflow_cnt increments; hit_cnt still increments.
  - Next state: TOKEN_WAIT if enable and token, else IDLE.
- Outputs are registered state decodes, one cycle behind state:
  - read(t+1) = (state(t) == READ).
  - freeze(t+1) = (state(t) is TOKEN_WAIT or READ).
  - busy(t+1) = (state(t) != IDLE).
- Cycles per word: cfg_wait + cfg_read + cfg_lat + 4 + DATA_W.
- Deasserting enable mid-word: the current word completes through STORE, then the block returns to IDLE.
- Token dropping before STORE does not abort the word.
- FIFO:
  - First-word-fall-through; out_data and out_valid are valid in the cycle after the push.
  - Pop when out_valid and out_ready.
  - Push while full is accepted if a pop occurs the same cycle.
  - Push and pop when empty: the pop is not possible (out_valid = 0); the push lands.
  - Occupancy never exceeds FIFO_DEPTH.
  - out_data holds its last value when empty.
- Counters saturate at all-ones and never wrap.

Decomposition:
- Package monopix_ro_pkg holds:
  - state enum {IDLE, TOKEN_WAIT, READ, LAT, SHIFT, STORE};
  - packed struct t_hit {col[5:0], te[5:0], le[5:0], row[8:0]};
  - localparam HIT_W = $bits(t_hit); DATA_W defaults to HIT_W.
- Sub-module monopix_ro_fifo (synchronous FWFT FIFO; push, pop, full, empty, count).
- The FSM, deserialiser and counters stay in monopix_readout_ctrl.

Test Plan:
- Basic word: DATA_W=27, cfg 2/1/3, token rises, data_in drives 0x5A5A5A5 MSB-first starting at the first SHIFT cycle. Expected: freeze high 5 cycles, read high 2 cycles starting 3 cycles after freeze; out_valid rises 37 cycles after token is sampled; out_data = 0x5A5A5A5; hit_cnt = 1.
- Back-to-back: token held high for 3 words. Expected: no IDLE between words, each word 37 cycles, FIFO holds 3 words in order, busy stays high throughout.
- Overflow: out_ready=0, FIFO_DEPTH=4, 6 words. Expected: FIFO keeps the first 4 words, overflow_cnt = 2, hit_cnt = 6. Then out_ready=1: 4 pops in order.
- Full with pop: FIFO full and out_ready=1 in the STORE cycle. Expected: word accepted, overflow_cnt unchanged, count stays 4.
- Enable and config change: enable dropped and cfg_wait changed mid-SHIFT. Expected: word completes with the old timing; IDLE follows even though token is still high; no further freeze.
- Reset mid-READ: reset asserted while read is high. Expected: next cycle read = freeze = busy = 0, FIFO empty, counters 0.
